// File: rtl/palindrome_pkg.sv
// Shared types and helpers for the serial palindrome checker.
// Latency: n/a (types, constants and a pure combinational function only).
// Backpressure: n/a.
// Contents: ctrl_state_e controller states, default widths, is_pal() window test.
package palindrome_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int WIN_W_DEF  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ctrl_state_e;

  // True when the low 'width' bits of vec read the same in both directions.
  // Bits at or above 'width' are ignored; width must be in 1..32.
  function automatic logic is_pal(input logic [31:0] vec, input int width);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i < width / 2) begin
        if (vec[5'(i)] != vec[5'(width - 1 - i)]) ok = 1'b0;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/palindrome_window.sv
// Serial palindrome window: flags when the last WIN_W bits (incl. bit_i) are a palindrome.
// Latency: hit_o is combinational on the stored WIN_W-1 bits plus the current bit_i.
// Backpressure: none; the caller decides when to shift via shift_en_i.
// Ports: clk, reset (async active-low), clear_i (flush history, wins over shift),
//        shift_en_i (consume bit_i this cycle), bit_i (serial data), hit_o (window match).
module palindrome_window
  import palindrome_pkg::*;
#(
  parameter int WIN_W = WIN_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic shift_en_i,
  input  logic bit_i,
  output logic hit_o
);

  localparam int FILL_W = $clog2(WIN_W);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WIN_W - 1);

  logic [WIN_W-2:0] hist;
  logic [FILL_W-1:0] fill;
  logic [WIN_W-1:0] win;
  logic [31:0] win_ext;

  // Oldest bit sits at the MSB; orientation is irrelevant for a palindrome test.
  assign win = {hist, bit_i};

  always_comb begin
    win_ext = '0;
    win_ext[WIN_W-1:0] = win;
  end

  // A hit is only meaningful once WIN_W-1 real bits are stored ahead of bit_i,
  // so a freshly flushed window cannot match on its zeroed history.
  assign hit_o = shift_en_i && !clear_i && (fill == FILL_FULL) && is_pal(win_ext, WIN_W);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist <= '0;
      fill <= '0;
    end else if (clear_i) begin
      hist <= '0;
      fill <= '0;
    end else if (shift_en_i) begin
      hist <= win[WIN_W-2:0];
      if (fill != FILL_FULL) fill <= fill + 1'b1;
    end
  end

endmodule

// File: rtl/palindrome_seq_ctrl.sv
// Word-level controller: serializes each word MSB-first into palindrome_window and counts hits.
// Latency: out_valid_o rises DATA_W cycles after the accept edge; one word per DATA_W+2 cycles.
// Backpressure: result held in DONE until out_ready_i; in_ready_o is low outside IDLE (state only).
// Ports: clk, reset (async active-low), in_valid_i/in_ready_o/in_data_i (word in),
//        out_valid_o/out_ready_i/hit_cnt_o/any_hit_o (result out), busy_o (not IDLE).
module palindrome_seq_ctrl
  import palindrome_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int WIN_W  = WIN_W_DEF,
  localparam int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CNT_W-1:0]  hit_cnt_o,
  output logic              any_hit_o,
  output logic              busy_o
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  ctrl_state_e state, state_nxt;

  logic [DATA_W-1:0] data_sr;
  logic [CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  hit_cnt;
  logic              accept;
  logic              shift_en;
  logic              last_bit;
  logic              win_hit;

  assign last_bit = (bit_cnt == LAST_BIT);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and handshake outputs; all decoded from state alone so that
  // in_ready_o has no combinational path from out_ready_i.
  always_comb begin
    state_nxt   = state;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b1;
    accept      = 1'b0;
    shift_en    = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready_o = 1'b1;
        busy_o     = 1'b0;
        if (in_valid_i) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: word shift register, bit position and hit accumulator.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_sr <= '0;
      bit_cnt <= '0;
      hit_cnt <= '0;
    end else if (accept) begin
      data_sr <= in_data_i;
      bit_cnt <= '0;
      hit_cnt <= '0;
    end else if (shift_en) begin
      data_sr <= {data_sr[DATA_W-2:0], 1'b0};
      bit_cnt <= bit_cnt + 1'b1;
      hit_cnt <= hit_cnt + CNT_W'(win_hit);
    end
  end

  // Window is flushed on every accept so hits never straddle two words.
  palindrome_window #(
    .WIN_W(WIN_W)
  ) u_window (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (accept),
    .shift_en_i(shift_en),
    .bit_i     (data_sr[DATA_W-1]),
    .hit_o     (win_hit)
  );

  assign hit_cnt_o = hit_cnt;
  assign any_hit_o = (hit_cnt != '0);

endmodule
